// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter that serialises accesses onto a single
//   synchronous-read RAM port. A write takes one RAM cycle (WR). A read takes
//   two RAM cycles (RD1, RD2) with the data captured at the end of RD2. Every
//   access finishes with a one-cycle acknowledge (RESP).
//
// Ports:
//   clk_i        - single clock, all state changes on rising edge
//   rst_n_i      - asynchronous active-low reset
//   req_i[1:0]   - per-requester access request (bit n = requester n)
//   we_i[1:0]    - per-requester access type, 1 = write, 0 = read
//   addr0_i      - requester 0 word address
//   addr1_i      - requester 1 word address
//   wdata0_i     - requester 0 write data
//   wdata1_i     - requester 1 write data
//   gnt_o[1:0]   - one-hot grant, held for the whole serviced access
//   ack_o[1:0]   - one-cycle completion pulse to the granted requester
//   rdata_o      - shared read-return data, valid with ack_o on reads
//   ram_wr_en_o  - RAM write enable
//   ram_rd_en_o  - RAM read enable
//   ram_addr_o   - RAM word address
//   ram_wdata_o  - RAM write word (gated onto the bus by the top level)
//   ram_rdata_i  - RAM data bus as seen by the arbiter
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                ptr_q;
  logic                winner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                pick;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic                start;

  // Winner selection. With both requesting, the pointer decides; a lone
  // requester wins regardless of the pointer (req_i[1] alone selects 1,
  // req_i[0] alone selects 0).
  always_comb begin
    pick       = 1'b0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    if (req_i == 2'b11) begin
      pick = ptr_q;
    end else begin
      pick = req_i[1];
    end
    if (pick) begin
      pick_we    = we_i[1];
      pick_addr  = addr1_i;
      pick_wdata = wdata1_i;
    end else begin
      pick_we    = we_i[0];
      pick_addr  = addr0_i;
      pick_wdata = wdata0_i;
    end
  end

  assign start = (state_q == IDLE) && (req_i != 2'b00);

  // Next-state logic. RESP always returns to IDLE, so a request that is
  // still high after its ack is sampled again as a fresh request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = pick_we ? WR : RD1;
        end
      end
      WR:      state_d = RESP;
      RD1:     state_d = RD2;
      RD2:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, priority pointer and the access latches. The latches
  // are loaded only at the IDLE sampling edge, so requester inputs are
  // don't-care for the rest of the access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        winner_q <= pick;
        addr_q   <= pick_addr;
        wdata_q  <= pick_wdata;
      end
      // Pointer moves to the other requester as the access enters RESP.
      if ((state_d == RESP) && (state_q != RESP)) begin
        ptr_q <= ~winner_q;
      end
      // Read data is captured only at the closing edge of RD2.
      if (state_q == RD2) begin
        rdata_q <= ram_rdata_i;
      end
    end
  end

  // Outputs are decoded from the state register and the latched winner,
  // so they are glitch-free with respect to the requester inputs.
  always_comb begin
    gnt_o       = 2'b00;
    ack_o       = 2'b00;
    ram_wr_en_o = 1'b0;
    ram_rd_en_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o = 2'b00;
      end
      WR: begin
        gnt_o       = winner_q ? 2'b10 : 2'b01;
        ram_wr_en_o = 1'b1;
      end
      RD1, RD2: begin
        gnt_o       = winner_q ? 2'b10 : 2'b01;
        ram_rd_en_o = 1'b1;
      end
      RESP: begin
        gnt_o = winner_q ? 2'b10 : 2'b01;
        ack_o = winner_q ? 2'b10 : 2'b01;
      end
      default: begin
        gnt_o = 2'b00;
      end
    endcase
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

endmodule
